io_input_device: RTL and testbench
==================================

IO_INPUT_DEVICE -- requirements
Module: io_input_device

Interface
REQ-001 SHALL have parameter DBITS, default 32, data/address width.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 500000, consecutive stable cycles required to accept an input change; benches override to 4.
REQ-003 SHALL have parameters KDATA_ADDR / KCTRL_ADDR / SDATA_ADDR / SCTRL_ADDR, defaults 32'hF0000010 / 32'hF0000110 / 32'hF0000014 / 32'hF0000114.
REQ-004 SHALL use one clock and an asynchronous, active-low reset: clk  input  1  rising-edge clock; reset  input  1  asynchronous active-low reset.
REQ-005 addr  input  DBITS  CPU data address, full-width compared.
REQ-006 isLoad  input  1  CPU load strobe, one cycle per access.
REQ-007 isStore  input  1  CPU store strobe, one cycle per access.
REQ-008 wrData  input  DBITS  store data.
REQ-009 KEY  input  4  raw pushbuttons, active-low (0 = pressed).
REQ-010 SW  input  10  raw slide switches, active-high.
REQ-011 rdData  output  DBITS  registered load data.
REQ-012 rdValid  output  1  one-cycle pulse: rdData holds a mapped register value.
REQ-013 irq  output  1  (KCTRL.IE & KCTRL.Ready) | (SCTRL.IE & SCTRL.Ready), registered.

Function
REQ-014 KEY and SW SHALL each pass through a 2-flop synchronizer; KEY synchronizer resets to 4'hF, SW synchronizer to 0.
REQ-015 Each group (KEY vector, SW vector) SHALL have one debouncer: candidate register plus counter; synced value != candidate -> candidate <= synced, counter <= 0; else counter increments, saturating at DEBOUNCE_CYCLES.
REQ-016 Debounced value SHALL update to candidate on the edge where counter reaches DEBOUNCE_CYCLES and candidate differs from debounced; this edge is a change event for that group.
REQ-017 Pin-to-Ready latency for a clean change SHALL be exactly DEBOUNCE_CYCLES+3 rising edges; any glitch shorter than DEBOUNCE_CYCLES SHALL produce no event.
REQ-018 KDATA read value SHALL be {28'b0, ~debouncedKEY} (1 = pressed); SDATA SHALL be {22'b0, debouncedSW}.
REQ-019 KCTRL/SCTRL read value SHALL be {23'b0, IE, 6'b0, Overrun, Ready} (IE bit 8, Overrun bit 1, Ready bit 0).
REQ-020 Change event with Ready=0 SHALL set Ready; change event with Ready=1 SHALL set Ready and Overrun.
REQ-021 Load of DATA register SHALL clear that group's Ready on the same edge; Overrun unaffected.
REQ-022 Change event and DATA load on the same edge: Ready SHALL end at 1, Overrun SHALL NOT be set, rdData SHALL return the pre-update debounced value.
REQ-023 Store to CTRL: wrData[8] SHALL load IE; wrData[1]=0 SHALL clear Overrun, 1 leaves it; wrData[0] ignored (Ready read-only). Stores to DATA SHALL be ignored.
REQ-024 Store clearing Overrun coincident with an event that would set it: set SHALL win.
REQ-025 Load to a mapped address SHALL, on the next edge, drive rdData with the value and pulse rdValid for one cycle; otherwise rdData = 0 and rdValid = 0.
REQ-026 isLoad and isStore both high SHALL be treated as store only: no rdValid, no read side effect.
REQ-027 Unmapped addresses SHALL produce no state change and rdValid = 0.

Reset
REQ-028 reset low SHALL asynchronously clear debounced values (KEY released, SW 0), candidates, counters, Ready, Overrun, IE, rdData, rdValid, irq.
REQ-029 After reset release, nonzero SW SHALL yield a normal change event DEBOUNCE_CYCLES+3 edges later (SCTRL.Ready=1).
REQ-030 Reset asserted mid-debounce SHALL discard the pending change; no event after release unless inputs differ from reset values.

Verification (DEBOUNCE_CYCLES=4)
REQ-031 KEY 4'hF->4'hE held: SCTRL unchanged; KCTRL reads 32'h1 from edge 7; KDATA load -> rdData 32'h1, rdValid one cycle later; then KCTRL reads 0.
REQ-032 SW toggles 0->3FF->0 with 3-cycle pulse: no event, SCTRL stays 0.
REQ-033 Two KEY changes without read: KCTRL reads 32'h3; store KCTRL wrData 32'h100 -> reads 32'h101, irq=1; KDATA load -> KCTRL 32'h100, irq=0.
REQ-034 KDATA load on event edge: rdData old value, KCTRL afterwards 32'h1, Overrun 0.
REQ-035 isLoad&isStore to KCTRL: rdValid stays 0; load of 32'hF0000018: rdValid 0, no state change.
REQ-036 Reset pulse 2 cycles after SW change: no SCTRL.Ready before change reapplied; all outputs 0 during reset.

Source files
------------

// File: rtl/io_input_device.sv
// Memory-mapped pushbutton/switch input device: synchronizes and debounces KEY and SW,
// exposes DATA/CTRL registers per group and a level interrupt.
module io_input_device #(
  parameter int unsigned      DBITS           = 32,
  parameter int unsigned      DEBOUNCE_CYCLES = 500000,
  parameter logic [DBITS-1:0] KDATA_ADDR      = DBITS'(32'hF0000010),
  parameter logic [DBITS-1:0] KCTRL_ADDR      = DBITS'(32'hF0000110),
  parameter logic [DBITS-1:0] SDATA_ADDR      = DBITS'(32'hF0000014),
  parameter logic [DBITS-1:0] SCTRL_ADDR      = DBITS'(32'hF0000114)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DBITS-1:0] addr,
  input  logic             isLoad,
  input  logic             isStore,
  input  logic [DBITS-1:0] wrData,
  input  logic [3:0]       KEY,
  input  logic [9:0]       SW,
  output logic [DBITS-1:0] rdData,
  output logic             rdValid,
  output logic             irq
);

  localparam int unsigned     CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

  logic [3:0]       key_meta_q, key_sync_q, key_cand_q, key_cand_d, key_deb_q, key_deb_d;
  logic [9:0]       sw_meta_q, sw_sync_q, sw_cand_q, sw_cand_d, sw_deb_q, sw_deb_d;
  logic [CNT_W-1:0] key_cnt_q, key_cnt_d, sw_cnt_q, sw_cnt_d;
  logic             key_evt_c, sw_evt_c;

  logic             key_rdy_q, key_rdy_d, key_ovr_q, key_ovr_d, key_ie_q, key_ie_d;
  logic             sw_rdy_q, sw_rdy_d, sw_ovr_q, sw_ovr_d, sw_ie_q, sw_ie_d;
  logic [DBITS-1:0] rd_data_q, rd_data_d;
  logic             rd_valid_q, rd_valid_d, irq_q, irq_d;

  logic             ld_c, rd_hit_c, kdata_rd_c, sdata_rd_c, kctrl_wr_c, sctrl_wr_c;
  logic [DBITS-1:0] rd_val_c;
  logic [3:0]       key_pressed_c;
  logic             unused_wrdata_c;

  assign unused_wrdata_c = ^{wrData[DBITS-1:9], wrData[7:2], wrData[0]};

  // KEY debouncer: an event fires on the edge the stable count reaches its limit
  always_comb begin
    key_cand_d = key_cand_q;
    key_cnt_d  = key_cnt_q;
    key_evt_c  = 1'b0;
    if (key_sync_q != key_cand_q) begin
      key_cand_d = key_sync_q;
      key_cnt_d  = '0;
    end else begin
      if (key_cnt_q != CNT_MAX) key_cnt_d = key_cnt_q + CNT_W'(1);
      key_evt_c = (key_cnt_d == CNT_MAX) && (key_cand_q != key_deb_q);
    end
    key_deb_d = key_evt_c ? key_cand_q : key_deb_q;
  end

  // SW debouncer
  always_comb begin
    sw_cand_d = sw_cand_q;
    sw_cnt_d  = sw_cnt_q;
    sw_evt_c  = 1'b0;
    if (sw_sync_q != sw_cand_q) begin
      sw_cand_d = sw_sync_q;
      sw_cnt_d  = '0;
    end else begin
      if (sw_cnt_q != CNT_MAX) sw_cnt_d = sw_cnt_q + CNT_W'(1);
      sw_evt_c = (sw_cnt_d == CNT_MAX) && (sw_cand_q != sw_deb_q);
    end
    sw_deb_d = sw_evt_c ? sw_cand_q : sw_deb_q;
  end

  // Bus decode and read mux; a simultaneous store suppresses the load entirely
  always_comb begin
    ld_c          = isLoad & ~isStore;
    key_pressed_c = ~key_deb_q;
    rd_hit_c      = 1'b1;
    rd_val_c      = '0;
    if (addr == KDATA_ADDR) begin
      rd_val_c = DBITS'(key_pressed_c);
    end else if (addr == KCTRL_ADDR) begin
      rd_val_c = DBITS'({key_ie_q, 6'b0, key_ovr_q, key_rdy_q});
    end else if (addr == SDATA_ADDR) begin
      rd_val_c = DBITS'(sw_deb_q);
    end else if (addr == SCTRL_ADDR) begin
      rd_val_c = DBITS'({sw_ie_q, 6'b0, sw_ovr_q, sw_rdy_q});
    end else begin
      rd_hit_c = 1'b0;
    end
    kdata_rd_c = ld_c & (addr == KDATA_ADDR);
    sdata_rd_c = ld_c & (addr == SDATA_ADDR);
    kctrl_wr_c = isStore & (addr == KCTRL_ADDR);
    sctrl_wr_c = isStore & (addr == SCTRL_ADDR);
    rd_valid_d = ld_c & rd_hit_c;
    rd_data_d  = rd_valid_d ? rd_val_c : '0;
  end

  // Status/control; an event always wins over a same-edge read clear or overrun clear
  always_comb begin
    key_rdy_d = key_evt_c | (key_rdy_q & ~kdata_rd_c);
    key_ovr_d = key_ovr_q;
    if (kctrl_wr_c && !wrData[1]) key_ovr_d = 1'b0;
    if (key_evt_c && key_rdy_q && !kdata_rd_c) key_ovr_d = 1'b1;
    key_ie_d  = kctrl_wr_c ? wrData[8] : key_ie_q;

    sw_rdy_d  = sw_evt_c | (sw_rdy_q & ~sdata_rd_c);
    sw_ovr_d  = sw_ovr_q;
    if (sctrl_wr_c && !wrData[1]) sw_ovr_d = 1'b0;
    if (sw_evt_c && sw_rdy_q && !sdata_rd_c) sw_ovr_d = 1'b1;
    sw_ie_d   = sctrl_wr_c ? wrData[8] : sw_ie_q;

    irq_d     = (key_ie_d & key_rdy_d) | (sw_ie_d & sw_rdy_d);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      key_meta_q <= 4'hF;
      key_sync_q <= 4'hF;
      key_cand_q <= 4'hF;
      key_deb_q  <= 4'hF;
      key_cnt_q  <= '0;
      sw_meta_q  <= '0;
      sw_sync_q  <= '0;
      sw_cand_q  <= '0;
      sw_deb_q   <= '0;
      sw_cnt_q   <= '0;
      key_rdy_q  <= 1'b0;
      key_ovr_q  <= 1'b0;
      key_ie_q   <= 1'b0;
      sw_rdy_q   <= 1'b0;
      sw_ovr_q   <= 1'b0;
      sw_ie_q    <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      key_meta_q <= KEY;
      key_sync_q <= key_meta_q;
      key_cand_q <= key_cand_d;
      key_deb_q  <= key_deb_d;
      key_cnt_q  <= key_cnt_d;
      sw_meta_q  <= SW;
      sw_sync_q  <= sw_meta_q;
      sw_cand_q  <= sw_cand_d;
      sw_deb_q   <= sw_deb_d;
      sw_cnt_q   <= sw_cnt_d;
      key_rdy_q  <= key_rdy_d;
      key_ovr_q  <= key_ovr_d;
      key_ie_q   <= key_ie_d;
      sw_rdy_q   <= sw_rdy_d;
      sw_ovr_q   <= sw_ovr_d;
      sw_ie_q    <= sw_ie_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      irq_q      <= irq_d;
    end
  end

  assign rdData  = rd_data_q;
  assign rdValid = rd_valid_q;
  assign irq     = irq_q;

endmodule

// File: tb/tb_io_input_device.sv
// Scoreboard bench for io_input_device: loads push expected read data, a negedge
// monitor pops and compares whenever rdValid is presented.
module tb_io_input_device;

  localparam logic [31:0] KDATA = 32'hF0000010;
  localparam logic [31:0] KCTRL = 32'hF0000110;
  localparam logic [31:0] SDATA = 32'hF0000014;
  localparam logic [31:0] SCTRL = 32'hF0000114;
  localparam logic [31:0] UNMAP = 32'hF0000018;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] addr = '0;
  logic        isLoad = 1'b0;
  logic        isStore = 1'b0;
  logic [31:0] wrData = '0;
  logic [3:0]  KEY = 4'hF;
  logic [9:0]  SW = '0;
  logic [31:0] rdData;
  logic        rdValid;
  logic        irq;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_data[$];
  string       exp_name[$];

  io_input_device #(.DBITS(32), .DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .addr(addr), .isLoad(isLoad), .isStore(isStore),
    .wrData(wrData), .KEY(KEY), .SW(SW), .rdData(rdData), .rdValid(rdValid), .irq(irq)
  );

  always #5 clk = ~clk;

  // Monitor: every read response must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (rdValid) begin
      n_checks++;
      if (exp_data.size() == 0) begin
        n_errors++;
        $display("FAIL rd_unexpected: rdValid=1 rdData=%h, required no response", rdData);
      end else begin
        logic [31:0] e;
        string       nm;
        e  = exp_data.pop_front();
        nm = exp_name.pop_front();
        if (rdData !== e) begin
          n_errors++;
          $display("FAIL %s: rdData=%h, required %h", nm, rdData, e);
        end
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  task automatic access(input logic [31:0] a, input logic ld, input logic st,
                        input logic [31:0] wd);
    addr = a; isLoad = ld; isStore = st; wrData = wd;
    @(negedge clk);
    addr = '0; isLoad = 1'b0; isStore = 1'b0; wrData = '0;
  endtask

  task automatic load(input string nm, input logic [31:0] a, input logic [31:0] exp);
    exp_data.push_back(exp);
    exp_name.push_back(nm);
    access(a, 1'b1, 1'b0, '0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string nm);
    check({nm, "_rdData"}, rdData, 32'h0);
    check({nm, "_rdValid"}, {31'b0, rdValid}, 32'h0);
    check({nm, "_irq"}, {31'b0, irq}, 32'h0);
  endtask

  initial begin
    #1 check_reset_outputs("por");
    idle(3);
    reset = 1'b1;
    idle(3);
    load("kctrl_init", KCTRL, 32'h0);
    load("kdata_init", KDATA, 32'h0);

    // Clean KEY press: Ready rises exactly on edge 7
    KEY = 4'hE;
    idle(6);
    load("kctrl_edge7_old", KCTRL, 32'h0);
    load("kctrl_edge7", KCTRL, 32'h1);
    load("sctrl_untouched", SCTRL, 32'h0);
    load("kdata_press", KDATA, 32'h1);
    load("kctrl_cleared", KCTRL, 32'h0);

    // 3-cycle SW glitch must not produce an event
    SW = 10'h3FF;
    idle(3);
    SW = 10'h000;
    idle(15);
    load("sctrl_glitch", SCTRL, 32'h0);
    load("sdata_glitch", SDATA, 32'h0);

    // Two events without a read -> overrun; IE store, irq, DATA read clears Ready
    KEY = 4'hC;
    idle(10);
    KEY = 4'h8;
    idle(10);
    load("kctrl_overrun", KCTRL, 32'h3);
    access(KCTRL, 1'b0, 1'b1, 32'h100);
    check("irq_after_ie", {31'b0, irq}, 32'h1);
    load("kctrl_ie_ready", KCTRL, 32'h101);
    load("kdata_three", KDATA, 32'h7);
    check("irq_after_read", {31'b0, irq}, 32'h0);
    load("kctrl_ie_only", KCTRL, 32'h100);
    access(KCTRL, 1'b0, 1'b1, 32'h0);

    // DATA load on the event edge with Ready already 1
    KEY = 4'hE;
    idle(10);
    KEY = 4'hF;
    idle(6);
    load("kdata_event_edge", KDATA, 32'h1);
    load("kctrl_after_race", KCTRL, 32'h1);
    load("kdata_released", KDATA, 32'h0);
    load("kctrl_final", KCTRL, 32'h0);

    // Load+store together is a store only; unmapped loads do nothing
    access(KCTRL, 1'b1, 1'b1, 32'h100);
    check("ldst_rdValid", {31'b0, rdValid}, 32'h0);
    load("kctrl_ldst_store", KCTRL, 32'h100);
    KEY = 4'hE;
    idle(10);
    check("irq_event", {31'b0, irq}, 32'h1);
    access(KDATA, 1'b1, 1'b1, 32'h0);
    check("ldst_kdata_rdValid", {31'b0, rdValid}, 32'h0);
    check("ldst_kdata_irq", {31'b0, irq}, 32'h1);
    load("kctrl_ready_kept", KCTRL, 32'h101);
    access(UNMAP, 1'b1, 1'b0, '0);
    check("unmapped_rdValid", {31'b0, rdValid}, 32'h0);
    load("kctrl_unmapped", KCTRL, 32'h101);
    load("kdata_clear", KDATA, 32'h1);
    check("irq_cleared", {31'b0, irq}, 32'h0);
    access(KCTRL, 1'b0, 1'b1, 32'h0);

    // Reset mid-debounce discards the pending SW change
    SW = 10'h3FF;
    idle(2);
    reset = 1'b0;
    SW = 10'h000;
    KEY = 4'hF;
    #1 check_reset_outputs("mid_reset");
    idle(2);
    reset = 1'b1;
    idle(12);
    load("sctrl_discarded", SCTRL, 32'h0);
    load("sdata_discarded", SDATA, 32'h0);
    load("kctrl_reset", KCTRL, 32'h0);

    // Nonzero SW held across reset release gives a normal event on edge 7
    reset = 1'b0;
    SW = 10'h155;
    idle(2);
    reset = 1'b1;
    idle(6);
    load("sctrl_rel_old", SCTRL, 32'h0);
    load("sctrl_rel", SCTRL, 32'h1);
    load("sdata_rel", SDATA, 32'h155);
    load("sctrl_rel_clr", SCTRL, 32'h0);

    idle(3);
    check("pending_reads", 32'(exp_data.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
